// File: rtl/fpu_link_pkg.sv
// Shared definitions for the FPU pin protocol. Used by the host-side
// initiator and the FPU-side logic.
//   link_state_t : host link FSM states
//   PIN_CTRL     : io_in bit carrying the ctrl strobe
//   PIN_SEL      : io_in bit carrying the add/mul select
//   PIN_VALID    : io_out bit flagging a valid result byte
//   NIBBLES      : nibble cycles per request
//   BYTES        : byte cycles per result
//   pin_word()   : packs one io_in word
package fpu_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_COMMIT,
        ST_WAIT,
        ST_CAP_HI,
        ST_RESP
    } link_state_t;

    localparam int PIN_CTRL  = 9;
    localparam int PIN_SEL   = 8;
    localparam int PIN_VALID = 8;
    localparam int NIBBLES   = 4;
    localparam int BYTES     = 2;

    // io_in word: [3:0] A nibble, [7:4] B nibble, select, ctrl; [11:10] stay 0.
    function automatic logic [11:0] pin_word(input logic ctrl, input logic sel,
                                             input logic [3:0] b_nib,
                                             input logic [3:0] a_nib);
        logic [11:0] w;
        w           = '0;
        w[3:0]      = a_nib;
        w[7:4]      = b_nib;
        w[PIN_SEL]  = sel;
        w[PIN_CTRL] = ctrl;
        return w;
    endfunction

endpackage

// File: rtl/fpu_link_timer.sv
// Load/decrement/expire counter used as the WAIT timeout.
//   clock, reset : clock and synchronous active-high reset
//   load         : load load_value (takes priority over dec)
//   load_value   : count to start from
//   dec          : decrement by one (saturates at 0)
//   expired      : high while the count is 1, i.e. the current edge is the
//                  load_value-th decrement edge since loading
module fpu_link_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == WIDTH'(1));

endmodule

// File: rtl/fpu_host_link.sv
// Host-side initiator for the FPU pin protocol. Serialises a parallel
// request (two half-precision operands plus select) onto io_in as four
// nibble cycles, holds ctrl for a commit window, then collects the 16-bit
// result from io_out as two byte cycles and offers it on a response
// handshake.
//   clock, reset          : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_a, req_b, req_sel : operands and select (1 = add, 0 = mul)
//   resp_valid/resp_ready : response handshake, response held until taken
//   resp_data, resp_err   : captured result, timeout flag
//   pin_out               : to FPU io_in
//   pin_in                : from FPU io_out
// Build option FPU_HOST_TIMEOUT_EN: when defined, WAIT gives up after
// TIMEOUT edges without a valid byte and reports resp_err; when undefined,
// WAIT persists and resp_err is tied low.
module fpu_host_link
    import fpu_link_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        req_sel,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic [11:0] pin_out,
    input  logic [11:0] pin_in
);

    localparam int DATA_W = 8 * BYTES;

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("HOLD_CYCLES out of range 1..15");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT out of range 2..255");
    end

    link_state_t       state_reg, state_next;
    logic [1:0]        nib_reg, nib_next;
    logic [3:0]        hold_reg, hold_next;
    logic [15:0]       a_reg, a_next;
    logic [15:0]       b_reg, b_next;
    logic              sel_reg, sel_next;
    logic [11:0]       pin_out_reg, pin_out_next;
    logic              resp_valid_reg, resp_valid_next;
    logic [DATA_W-1:0] resp_data_reg, resp_data_next;
    logic              resp_err_reg, resp_err_next;

    // io_out[11:9] carry nothing for the host.
    logic unused_pins;
    assign unused_pins = ^pin_in[11:9];

`ifdef FPU_HOST_TIMEOUT_EN
    logic timer_load;
    logic timer_dec;
    logic timer_expired;

    fpu_link_timer #(
        .WIDTH(8)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (8'(TIMEOUT)),
        .dec        (timer_dec),
        .expired    (timer_expired)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            nib_reg        <= '0;
            hold_reg       <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            sel_reg        <= 1'b0;
            pin_out_reg    <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            nib_reg        <= nib_next;
            hold_reg       <= hold_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            sel_reg        <= sel_next;
            pin_out_reg    <= pin_out_next;
            resp_valid_reg <= resp_valid_next;
            resp_data_reg  <= resp_data_next;
            resp_err_reg   <= resp_err_next;
        end
    end

    // Next state, plus registered outputs decoded from the *next* state so
    // pin_out and resp_valid line up with the state they belong to.
    always_comb begin
        state_next      = state_reg;
        nib_next        = nib_reg;
        hold_next       = hold_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        sel_next        = sel_reg;
        resp_data_next  = resp_data_reg;
        resp_err_next   = resp_err_reg;
        pin_out_next    = '0;
        resp_valid_next = 1'b0;
`ifdef FPU_HOST_TIMEOUT_EN
        timer_load      = 1'b0;
        timer_dec       = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    a_next         = req_a;
                    b_next         = req_b;
                    sel_next       = req_sel;
                    nib_next       = '0;
                    resp_data_next = '0;
                    resp_err_next  = 1'b0;
                    state_next     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (nib_reg == 2'(NIBBLES - 1)) begin
                    hold_next  = '0;
                    state_next = ST_COMMIT;
                end else begin
                    nib_next = nib_reg + 2'd1;
                end
            end
            ST_COMMIT: begin
                if (hold_reg == 4'(HOLD_CYCLES - 1)) begin
                    state_next = ST_WAIT;
`ifdef FPU_HOST_TIMEOUT_EN
                    timer_load = 1'b1;
`endif
                end else begin
                    hold_next = hold_reg + 4'd1;
                end
            end
            ST_WAIT: begin
                // A valid byte wins over a simultaneous timeout.
                if (pin_in[PIN_VALID]) begin
                    resp_data_next[7:0] = pin_in[7:0];
                    state_next          = ST_CAP_HI;
                end
`ifdef FPU_HOST_TIMEOUT_EN
                else if (timer_expired) begin
                    resp_data_next = '0;
                    resp_err_next  = 1'b1;
                    state_next     = ST_RESP;
                end else begin
                    timer_dec = 1'b1;
                end
`endif
            end
            ST_CAP_HI: begin
                // The second byte follows the first unconditionally.
                resp_data_next[15:8] = pin_in[7:0];
                state_next           = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        case (state_next)
            ST_SEND:   pin_out_next = pin_word(1'b1, sel_next,
                                               b_next[{nib_next, 2'b00} +: 4],
                                               a_next[{nib_next, 2'b00} +: 4]);
            ST_COMMIT: pin_out_next = pin_word(1'b1, sel_next, 4'h0, 4'h0);
            ST_WAIT,
            ST_CAP_HI: pin_out_next = pin_word(1'b0, sel_next, 4'h0, 4'h0);
            ST_RESP:   resp_valid_next = 1'b1;
            default:   pin_out_next = '0;
        endcase
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign pin_out    = pin_out_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
`ifdef FPU_HOST_TIMEOUT_EN
    assign resp_err   = resp_err_reg;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: doc/fpu_host_link.md
# fpu_host_link

Host-side initiator for the FPU pin protocol. It takes a parallel request (two 16-bit half-precision operands plus an add/multiply select) and serialises it onto the FPU's 12-bit pin input as four nibble cycles. It then collects the 16-bit result from the FPU's 12-bit pin output as two byte cycles and returns it on a parallel response handshake. It sits between a test/host controller and the FPU chip pins: pin_out drives the FPU's io_in, and pin_in samples its io_out.

## Interface
Parameters:
- HOLD_CYCLES, 2: cycles ctrl stays high after the last nibble (commit window), range 1..15.
- TIMEOUT, 64: WAIT cycles allowed before giving up, range 2..255.

Ports:
- Clocking: reset, synchronous, active-high; clock clock.
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_a  in  16  operand A.
- req_b  in  16  operand B.
- req_sel  in  1  1 = add result, 0 = mul result.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  16  captured result.
- resp_err  out  1  timeout, no valid byte seen.
- pin_out  out  12  to FPU io_in: [3:0] A nibble, [7:4] B nibble, [8] select, [9] ctrl, [11:10] always 0.
- pin_in  in  12  from FPU io_out: [7:0] result byte, [8] valid, [11:9] ignored.

## Operation
- States: IDLE, SEND, COMMIT, WAIT, CAP_HI, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_a, req_b and req_sel, clear the nibble index, and go to SEND.
- SEND:
  - Per cycle, pin_out[3:0]=A[4k+3:4k], pin_out[7:4]=B[4k+3:4k], for k=0..3 (LSB nibble first).
  - pin_out[9]=1.
  - After k=3, go to COMMIT.
- COMMIT:
  - pin_out[7:0]=0, pin_out[9]=1, for HOLD_CYCLES cycles.
  - Then go to WAIT.
- WAIT:
  - pin_out[9]=0, pin_out[7:0]=0.
  - Each edge, sample pin_in.
  - If pin_in[8]=1, capture pin_in[7:0] as resp_data[7:0] and go to CAP_HI.
- CAP_HI:
  - Capture pin_in[7:0] as resp_data[15:8] unconditionally, regardless of pin_in[8].
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_err held stable.
  - On resp_ready, go to IDLE.
- pin_out[8]=latched select from SEND through CAP_HI; 0 in IDLE and RESP.
- All outputs are registered, except req_ready, which is decoded from state.

## Timing
- Reset values: pin_out=0, resp_valid=0, resp_data=0, resp_err=0, state=IDLE, so req_ready=1 on the first cycle after reset.
- Request accepted at edge T:
  - Nibbles k=0..3 appear on pin_out during T+1..T+4.
  - Commit window occupies T+5..T+4+HOLD_CYCLES.
  - ctrl drops at T+5+HOLD_CYCLES.
- Byte capture:
  - Low byte is captured at the first WAIT edge with pin_in[8]=1 (edge V).
  - High byte is captured at V+1.
  - resp_valid rises at V+2.
- Timeout:
  - The WAIT counter is cleared on entry.
  - If TIMEOUT edges pass without pin_in[8], go to RESP with resp_err=1 and resp_data=0.
- Back-to-back: a new request is accepted no earlier than the cycle after the resp_valid&&resp_ready edge. There is no overlap, and req_ready=0 during RESP even if req_valid is high.
- pin_in[8] high on the very first WAIT edge is valid; the capture proceeds.
- pin_in is ignored outside WAIT and CAP_HI.
- Reset mid-transaction:
  - Next edge, state goes to IDLE and pin_out=0 (ctrl drops immediately).
  - Any pending response is discarded.

## Configuration
- FPU_HOST_TIMEOUT_EN:
  - Defined: the WAIT timeout counter and resp_err behave as above.
  - Undefined: no counter; WAIT persists until pin_in[8]=1; resp_err is tied 0; TIMEOUT is unused.

## Structure
- Package fpu_link_pkg holds:
  - the state enum;
  - pin index constants PIN_CTRL=9, PIN_SEL=8, PIN_VALID=8;
  - NIBBLES=4 and BYTES=2.
  The FPU-side logic shares these constants.
- One natural sub-module: fpu_link_timer, a load/decrement/expire counter. It is instantiated only under FPU_HOST_TIMEOUT_EN.

## Test plan
- Serialisation: req_a=16'h3C00, req_b=16'h4000, req_sel=1.
  - pin_out[7:0] sequence is 0x00, 0x00, 0x0C, 0x43 with pin_out[9:8]=2'b11.
  - Then HOLD_CYCLES cycles of 0x00 with ctrl=1, then ctrl=0.
- Result capture: the FPU model drives valid plus byte 0x00, then byte 0x42, three cycles into WAIT.
  - resp_valid rises 2 cycles after the valid byte; resp_data=16'h4200, resp_err=0.
- Response backpressure: hold resp_ready=0 for 10 cycles.
  - resp_valid and resp_data stay stable; req_ready=0 throughout.
  - Accept resp, then issue a new req: it is accepted the following cycle.
- Timeout (macro defined, TIMEOUT=8): pin_in[8] is never asserted.
  - RESP is reached after 8 WAIT edges with resp_err=1 and resp_data=0.
- Reset mid-SEND: assert reset at nibble k=2.
  - pin_out=0 the next cycle; req_ready=1 after reset is released.
  - No resp_valid is produced.
- Mul path: req_sel=0, A=16'h4000, B=16'h4200.
  - pin_out[8]=0 for the whole transaction.
  - The model returns 16'h4600, and resp_data=16'h4600.
